csr_unit: RTL and testbench

Machine-mode CSR unit for the RV32 core, successor to the flat 4096-entry CSR array. Implements only the architected M-mode CSRs as discrete registers with per-register write masks, atomic read-modify-write ops (CSRRW/RS/RC), trap entry/MRET state updates, 64-bit cycle/instret counters and interrupt-pending generation. Sits beside the integer regfile: read in EX, written at the same clock edge as the regfile writeback, driven by the trap logic in the control path.

---
 rtl/csr_pkg.sv | 51 +++++
 rtl/csr_unit_counter.sv | 29 ++
 rtl/csr_unit.sv | 173 +++++++++++++++++
 tb/tb_csr_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// architected bit positions and write masks.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSIP     = 3;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;
  localparam logic [31:0] MIE_WMASK   = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_RW: return wdata;
      CSR_OP_RS: return old_val | wdata;
      CSR_OP_RC: return old_val & ~wdata;
      default:   return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit_counter.sv
// 64-bit performance counter; a write to either half replaces that half and
// suppresses the increment for that cycle.
module csr_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i)      cnt_d[31:0]  = wdata_i;
    else if (wr_hi_i) cnt_d[63:32] = wdata_i;
    else if (inc_i)   cnt_d        = cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: discrete architected registers, atomic RW/RS/RC,
// trap entry / MRET state updates, counters and interrupt-pending output.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter bit          HAS_COUNTERS = 1'b1,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter int          HART_ID      = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            instret_inc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending
);

  csr_op_e     op;
  logic        implemented, csr_we;
  logic [31:0] wval, mstatus_rd, mip_rd, tvec_base;
  logic [63:0] mcycle, minstret;

  logic        mie_en_q, mie_en_d, mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_rd               = '0;
    mstatus_rd[12:11]        = 2'b11;
    mstatus_rd[MSTATUS_MIE]  = mie_en_q;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
    mip_rd                   = '0;
    mip_rd[MIP_MSIP]         = irq_soft;
    mip_rd[MIP_MTIP]         = irq_timer;
    mip_rd[MIP_MEIP]         = irq_ext;
  end

  always_comb begin
    csr_rdata   = '0;
    implemented = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MISA:      csr_rdata = MISA_VALUE;
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP:       csr_rdata = mip_rd;
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_rdata = '0;
      CSR_MHARTID:   csr_rdata = 32'(HART_ID);
      default:       implemented = 1'b0;
    endcase
  end

  assign csr_illegal = (op != CSR_OP_NONE) && (!implemented || csr_addr[11:10] == 2'b11);
  // Trap and MRET own the cycle; a coincident CSR write is dropped entirely.
  assign csr_we      = (op != CSR_OP_NONE) && !csr_illegal && !trap_valid && !mret;
  assign wval        = csr_apply(op, csr_rdata, csr_wdata);

  always_comb begin
    mie_en_d   = mie_en_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_valid) begin
      mepc_d   = trap_pc & MEPC_WMASK;
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
      mpie_d   = mie_en_q;
      mie_en_d = 1'b0;
    end else if (mret) begin
      mie_en_d = mpie_q;
      mpie_d   = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_en_d = wval[MSTATUS_MIE];
          mpie_d   = wval[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wval & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = wval & MTVEC_WMASK;
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval & MEPC_WMASK;
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_en_q   <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_en_q   <= mie_en_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  generate
    if (HAS_COUNTERS) begin : g_counters
      csr_counter u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (1'b1),
        .wr_lo_i (csr_we && csr_addr == CSR_MCYCLE),
        .wr_hi_i (csr_we && csr_addr == CSR_MCYCLEH),
        .wdata_i (wval),
        .count_o (mcycle)
      );
      csr_counter u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (instret_inc),
        .wr_lo_i (csr_we && csr_addr == CSR_MINSTRET),
        .wr_hi_i (csr_we && csr_addr == CSR_MINSTRETH),
        .wdata_i (wval),
        .count_o (minstret)
      );
    end else begin : g_no_counters
      assign mcycle   = '0;
      assign minstret = '0;
    end
  endgenerate

  // Vectored mode offsets only interrupts; exceptions always land on the base.
  assign tvec_base   = {mtvec_q[31:2], 2'b00};
  assign trap_target = (mtvec_q[0] && trap_cause[31])
                       ? tvec_base + ({1'b0, trap_cause[30:0]} << 2)
                       : tvec_base;
  assign mepc_o      = mepc_q;
  assign irq_pending = mie_en_q & |(mie_q & mip_rd);

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: a vector table of single-cycle CSR ops
// followed by hand-written trap, MRET, counter and reset sequences.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal;
  logic        trap_valid, mret, instret_inc;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        irq_ext, irq_timer, irq_soft;
  logic [31:0] trap_target, mepc_o;
  logic        irq_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_unit #(
    .XLEN         (32),
    .HAS_COUNTERS (1'b1),
    .MTVEC_RESET  (32'h0000_0200),
    .HART_ID      (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_tval   (trap_tval),
    .mret        (mret),
    .instret_inc (instret_inc),
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .irq_soft    (irq_soft),
    .trap_target (trap_target),
    .mepc_o      (mepc_o),
    .irq_pending (irq_pending)
  );

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    @(negedge clk);
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = d;
    @(posedge clk);
    #1;
    csr_op = 2'b00;
  endtask

  task automatic csr_read(input string name, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk);
    csr_addr = a;
    csr_op   = 2'b00;
    #1;
    chk(name, csr_rdata, exp);
    $display("read  %s addr=%h rdata=%h", name, a, csr_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{12'h305, 2'b00, 32'h0000_0000, 32'h0000_0200, 1'b0};
    vecs[1]  = '{12'h300, 2'b00, 32'h0000_0000, 32'h0000_1800, 1'b0};
    vecs[2]  = '{12'hF14, 2'b00, 32'h0000_0000, 32'h0000_0003, 1'b0};
    vecs[3]  = '{12'h301, 2'b00, 32'h0000_0000, 32'h4000_0100, 1'b0};
    vecs[4]  = '{12'h340, 2'b01, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[5]  = '{12'h340, 2'b10, 32'h0000_00F0, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{12'h340, 2'b11, 32'h0000_000F, 32'hDEAD_BEFF, 1'b0};
    vecs[7]  = '{12'h340, 2'b00, 32'h0000_0000, 32'hDEAD_BEF0, 1'b0};
    vecs[8]  = '{12'h300, 2'b01, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0};
    vecs[9]  = '{12'h300, 2'b00, 32'h0000_0000, 32'h0000_1888, 1'b0};
    vecs[10] = '{12'hF14, 2'b01, 32'h0000_0005, 32'h0000_0003, 1'b1};
    vecs[11] = '{12'hF14, 2'b00, 32'h0000_0000, 32'h0000_0003, 1'b0};
    vecs[12] = '{12'h7C0, 2'b01, 32'h0000_1234, 32'h0000_0000, 1'b1};
    vecs[13] = '{12'h7C0, 2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[14] = '{12'h304, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[15] = '{12'h304, 2'b00, 32'h0000_0000, 32'h0000_0888, 1'b0};
    vecs[16] = '{12'h341, 2'b01, 32'h0000_1237, 32'h0000_0000, 1'b0};
    vecs[17] = '{12'h341, 2'b00, 32'h0000_0000, 32'h0000_1234, 1'b0};
    vecs[18] = '{12'h305, 2'b01, 32'hFFFF_FFFF, 32'h0000_0200, 1'b0};
    vecs[19] = '{12'h305, 2'b00, 32'h0000_0000, 32'hFFFF_FFFD, 1'b0};
    vecs[20] = '{12'hF11, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[21] = '{12'h301, 2'b01, 32'h0000_0000, 32'h4000_0100, 1'b0};
    vecs[22] = '{12'h301, 2'b00, 32'h0000_0000, 32'h4000_0100, 1'b0};
    vecs[23] = '{12'h300, 2'b11, 32'h0000_0008, 32'h0000_1888, 1'b0};
    vecs[24] = '{12'h300, 2'b00, 32'h0000_0000, 32'h0000_1880, 1'b0};

    rst_n = 1'b0;
    csr_addr = '0; csr_op = 2'b00; csr_wdata = '0;
    trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mret = 1'b0; instret_inc = 1'b0;
    irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_irq_pending", {31'd0, irq_pending}, 32'd0);
    chk("reset_mepc_o", mepc_o, 32'h0);
    chk("reset_trap_target", trap_target, 32'h0000_0200);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      csr_addr  = vecs[i].addr;
      csr_op    = vecs[i].op;
      csr_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_illegal", i), {31'd0, csr_illegal}, {31'd0, vecs[i].exp_ill});
      $display("vec %0d addr=%h op=%0d wdata=%h rdata=%h illegal=%0b",
               i, csr_addr, csr_op, csr_wdata, csr_rdata, csr_illegal);
      @(posedge clk);
      #1;
      csr_op = 2'b00;
    end

    // Interrupt pending needs MIE, mie enable and a live line together.
    @(negedge clk);
    irq_timer = 1'b1;
    csr_read("mip_timer", 12'h344, 32'h0000_0080);
    chk("irq_pending_mie_off", {31'd0, irq_pending}, 32'd0);
    csr_write(12'h300, 2'b01, 32'h0000_0008);
    csr_read("mstatus_mie_only", 12'h300, 32'h0000_1808);
    chk("irq_pending_on", {31'd0, irq_pending}, 32'd1);
    irq_timer = 1'b0;
    #1;
    chk("irq_pending_line_low", {31'd0, irq_pending}, 32'd0);

    // Trap beats both MRET and a CSR write to mepc in the same cycle.
    csr_write(12'h305, 2'b01, 32'h0000_1001);
    @(negedge clk);
    trap_cause = 32'h8000_0007;
    trap_pc    = 32'h8000_0106;
    trap_tval  = 32'h0000_ABCD;
    #1;
    chk("trap_target_vectored_irq", trap_target, 32'h0000_101C);
    trap_valid = 1'b1;
    mret       = 1'b1;
    csr_addr   = 12'h341;
    csr_op     = 2'b01;
    csr_wdata  = 32'h5555_0000;
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    mret       = 1'b0;
    csr_op     = 2'b00;
    $display("trap  pc=%h cause=%h with mret and mepc write", trap_pc, trap_cause);
    chk("trap_mepc_o", mepc_o, 32'h8000_0104);
    csr_read("trap_mepc", 12'h341, 32'h8000_0104);
    csr_read("trap_mcause", 12'h342, 32'h8000_0007);
    csr_read("trap_mtval", 12'h343, 32'h0000_ABCD);
    csr_read("trap_mstatus", 12'h300, 32'h0000_1880);
    trap_cause = 32'h0000_0002;
    #1;
    chk("trap_target_vectored_exc", trap_target, 32'h0000_1000);

    // MRET drops a coincident mscratch write.
    @(negedge clk);
    mret      = 1'b1;
    csr_addr  = 12'h340;
    csr_op    = 2'b01;
    csr_wdata = 32'h0000_0000;
    @(posedge clk);
    #1;
    mret   = 1'b0;
    csr_op = 2'b00;
    $display("mret  with mscratch write");
    csr_read("mret_mstatus", 12'h300, 32'h0000_1888);
    csr_read("mret_mscratch", 12'h340, 32'hDEAD_BEF0);
    chk("mret_mepc_o", mepc_o, 32'h8000_0104);

    // Low-half write followed by a carry into the high half.
    csr_write(12'hB80, 2'b01, 32'h0000_0005);
    csr_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
    csr_addr = 12'hB00; #1;
    chk("mcycle_after_write", csr_rdata, 32'hFFFF_FFFF);
    csr_addr = 12'hB80; #1;
    chk("mcycleh_after_write", csr_rdata, 32'h0000_0005);
    @(posedge clk); #1;
    csr_addr = 12'hB00; #1;
    chk("mcycle_carry_lo", csr_rdata, 32'h0000_0000);
    csr_addr = 12'hB80; #1;
    chk("mcycle_carry_hi", csr_rdata, 32'h0000_0006);
    $display("count mcycle carry sequence");

    csr_write(12'hB80, 2'b01, 32'hFFFF_FFFF);
    csr_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    csr_addr = 12'hB00; #1;
    chk("mcycle_wrap_lo", csr_rdata, 32'h0000_0000);
    csr_addr = 12'hB80; #1;
    chk("mcycle_wrap_hi", csr_rdata, 32'h0000_0000);
    $display("count mcycle 64-bit wrap");

    csr_write(12'hB02, 2'b01, 32'h0000_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instret_inc = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    instret_inc = 1'b0;
    csr_addr = 12'hB02; #1;
    chk("minstret_10", csr_rdata, 32'd10);
    csr_addr = 12'hB82; #1;
    chk("minstreth_0", csr_rdata, 32'd0);
    $display("count minstret after 10 retires");

    // Reset wins over a trap presented in the same cycle.
    @(negedge clk);
    rst_n      = 1'b0;
    trap_valid = 1'b1;
    trap_pc    = 32'h0000_0040;
    irq_ext    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    trap_valid = 1'b0;
    csr_addr   = 12'hB00;
    #1;
    chk("rst_mcycle", csr_rdata, 32'h0);
    chk("rst_mepc_o", mepc_o, 32'h0);
    chk("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
    chk("rst_trap_target", trap_target, 32'h0000_0200);
    $display("reset during trap");
    csr_read("rst_mstatus", 12'h300, 32'h0000_1800);
    csr_read("rst_mscratch", 12'h340, 32'h0);
    csr_read("rst_mtvec", 12'h305, 32'h0000_0200);
    csr_read("rst_mcause", 12'h342, 32'h0);
    irq_ext = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
